// File: rtl/seq_divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_ctrl
// Description : Multi-cycle restoring integer divider (signed/unsigned) with
//               valid/ready handshakes and divide-by-zero / overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int c_ITER  = DATA_WIDTH / STEPS_PER_CYCLE;
    localparam int c_CNT_W = $clog2(c_ITER + 1);
    localparam logic [DATA_WIDTH-1:0] c_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_CNT_W-1:0]    r_count;
    logic [DATA_WIDTH:0]   r_prem;
    logic [DATA_WIDTH-1:0] r_dq;
    logic [DATA_WIDTH-1:0] r_div;
    logic                  r_neg_q;
    logic                  r_neg_r;

    logic                  w_accept;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic                  w_zero;
    logic                  w_ovf;
    logic [DATA_WIDTH:0]   w_prem;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH-1:0] w_dq;

    assign w_accept = in_valid & in_ready;
    assign w_a_neg  = signed_mode & dividend[DATA_WIDTH-1];
    assign w_b_neg  = signed_mode & divisor[DATA_WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~dividend + 1'b1) : dividend;
    assign w_b_mag  = w_b_neg ? (~divisor + 1'b1) : divisor;
    assign w_zero   = (divisor == '0);
    assign w_ovf    = signed_mode & (dividend == c_MIN) & (divisor == '1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next = (w_zero | w_ovf) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == c_CNT_W'(1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // r_dq starts as the dividend magnitude and fills with quotient bits from the right
    always_comb begin
        w_prem  = r_prem;
        w_dq    = r_dq;
        w_shift = '0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            w_shift = (w_prem << 1) | {{DATA_WIDTH{1'b0}}, w_dq[DATA_WIDTH-1]};
            if (w_shift >= {1'b0, r_div}) begin
                w_prem = w_shift - {1'b0, r_div};
                w_dq   = {w_dq[DATA_WIDTH-2:0], 1'b1};
            end else begin
                w_prem = w_shift;
                w_dq   = {w_dq[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count     <= '0;
            r_prem      <= '0;
            r_dq        <= '0;
            r_div       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_dq    <= w_a_mag;
                        r_div   <= w_b_mag;
                        r_prem  <= '0;
                        r_count <= c_CNT_W'(c_ITER);
                        if (w_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else if (w_ovf) begin
                            quotient  <= c_MIN;
                            remainder <= '0;
                            overflow  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_prem  <= w_prem;
                    r_dq    <= w_dq;
                    r_count <= r_count - 1'b1;
                end
                S_FIX: begin
                    // Truncating division: remainder follows the dividend's sign
                    quotient  <= r_neg_q ? (~r_dq + 1'b1) : r_dq;
                    remainder <= r_neg_r ? (~r_prem[DATA_WIDTH-1:0] + 1'b1)
                                         : r_prem[DATA_WIDTH-1:0];
                end
                S_DONE: begin
                    if (out_ready) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
